// File: rtl/mux_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scan_ctrl_pkg
//
// Shared definitions for the mux scan sequencer:
//   - state_t      : sequencer states (IDLE, ENTER, SETTLE, SAMPLE, DONE)
//   - SCAN_WIDTH   : default number of mux channels
//   - SCAN_LOG_WIDTH : default select width (ceil(log2(SCAN_WIDTH)))
//   - SCAN_DWELL_W : default settle-counter width
// -----------------------------------------------------------------------------
package scan_ctrl_pkg;

  localparam int SCAN_WIDTH     = 32;
  localparam int SCAN_LOG_WIDTH = 5;
  localparam int SCAN_DWELL_W   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENTER  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_bit_mux.sv
// -----------------------------------------------------------------------------
// scan_bit_mux
//
// WIDTH:1 single-bit multiplexer feeding the scan controller.
//
// Ports:
//   data [WIDTH]     : mux data inputs
//   sel  [LOG_WIDTH] : channel select (the controller keeps it <= WIDTH-1)
//   out  [1]         : data[sel]
// -----------------------------------------------------------------------------
module scan_bit_mux #(
  parameter int WIDTH     = 32,
  parameter int LOG_WIDTH = 5
) (
  input  logic [WIDTH-1:0]     data,
  input  logic [LOG_WIDTH-1:0] sel,
  output logic                 out
);

  assign out = data[sel];

endmodule

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
//
// Scan sequencer for a WIDTH:1 bit mux over the user I/O inputs. A start
// request latches dwell and mask, then walks the channels in order: masked
// channels are skipped in one cycle, unmasked channels get an ENTER cycle,
// dwell_q+1 SETTLE cycles and one SAMPLE cycle in which the selected bit is
// captured into the working frame. The completed frame is published on
// frame_o with a one-cycle frame_valid_o pulse. In continuous mode a new
// frame starts directly after the single DONE cycle.
//
// Ports:
//   wb_clk_i        in   clock
//   wb_rst_i        in   synchronous active-high reset
//   start_i         in   start scan (only honoured in IDLE)
//   stop_i          in   abort scan from any busy state (wins over all)
//   continuous_i    in   restart after each frame (sampled in DONE)
//   dwell_i         in   extra settle cycles per channel (latched per frame)
//   mask_i          in   1 = skip channel (latched per frame)
//   data_i          in   mux data inputs
//   sel_o           out  current mux select (registered)
//   busy_o          out  sequencer not in IDLE
//   frame_o         out  last completed frame
//   frame_valid_o   out  one-cycle pulse when frame_o updates
//   irq_clr_i       in   clears irq_o
//   irq_o           out  sticky frame-complete interrupt
//
// Build option:
//   SCAN_IRQ_EN     when defined, irq_o is a sticky flag set with every
//                   frame_valid_o pulse and cleared by irq_clr_i (set wins).
//                   When undefined, irq_o is tied low and irq_clr_i unused.
// -----------------------------------------------------------------------------
module mux_scan_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int WIDTH     = SCAN_WIDTH,
  parameter int LOG_WIDTH = SCAN_LOG_WIDTH,
  parameter int DWELL_W   = SCAN_DWELL_W
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 continuous_i,
  input  logic [DWELL_W-1:0]   dwell_i,
  input  logic [WIDTH-1:0]     mask_i,
  input  logic [WIDTH-1:0]     data_i,
  output logic [LOG_WIDTH-1:0] sel_o,
  output logic                 busy_o,
  output logic [WIDTH-1:0]     frame_o,
  output logic                 frame_valid_o,
  input  logic                 irq_clr_i,
  output logic                 irq_o
);

  localparam logic [LOG_WIDTH-1:0] LAST_SEL = LOG_WIDTH'(WIDTH - 1);
  localparam logic [LOG_WIDTH-1:0] SEL_ONE  = LOG_WIDTH'(1);
  localparam logic [DWELL_W-1:0]   CNT_ONE  = DWELL_W'(1);

  state_t               state;
  logic [LOG_WIDTH-1:0] sel;
  logic [DWELL_W-1:0]   cnt;
  logic [DWELL_W-1:0]   dwell_q;
  logic [WIDTH-1:0]     mask_q;
  logic [WIDTH-1:0]     work;
  logic [WIDTH-1:0]     frame;
  logic                 frame_valid;

  logic                 sel_bit;
  logic                 sel_last;
  logic                 abort;
  logic                 frame_done;

  scan_bit_mux #(
    .WIDTH     (WIDTH),
    .LOG_WIDTH (LOG_WIDTH)
  ) u_bit_mux (
    .data (data_i),
    .sel  (sel),
    .out  (sel_bit)
  );

  // The select never advances past the last channel; reaching it ends the frame.
  assign sel_last   = (sel == LAST_SEL);
  // stop_i only matters once a scan is running; in IDLE it just blocks start_i.
  assign abort      = stop_i && (state != IDLE);
  // The DONE cycle publishes the frame unless it is being aborted.
  assign frame_done = (state == DONE) && !stop_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      sel         <= '0;
      cnt         <= '0;
      dwell_q     <= '0;
      mask_q      <= '0;
      work        <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (abort) begin
        // Partial frame is dropped; frame/frame_valid keep the last good frame.
        state <= IDLE;
        sel   <= '0;
        work  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i && !stop_i) begin
              state   <= ENTER;
              sel     <= '0;
              dwell_q <= dwell_i;
              mask_q  <= mask_i;
              work    <= '0;
            end
          end

          ENTER: begin
            if (mask_q[sel]) begin
              // Skipped channel: one cycle, bit forced to zero.
              work[sel] <= 1'b0;
              if (sel_last) begin
                state <= DONE;
              end else begin
                sel <= sel + SEL_ONE;
              end
            end else begin
              cnt   <= dwell_q;
              state <= SETTLE;
            end
          end

          SETTLE: begin
            // Counts dwell_q down to zero, so the mux settles dwell_q+1 cycles.
            if (cnt == '0) begin
              state <= SAMPLE;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end

          SAMPLE: begin
            work[sel] <= sel_bit;
            if (sel_last) begin
              state <= DONE;
            end else begin
              sel   <= sel + SEL_ONE;
              state <= ENTER;
            end
          end

          DONE: begin
            frame       <= work;
            frame_valid <= 1'b1;
            sel         <= '0;
            if (continuous_i) begin
              // Back-to-back frame: relatch configuration exactly as a start would.
              state   <= ENTER;
              dwell_q <= dwell_i;
              mask_q  <= mask_i;
              work    <= '0;
            end else begin
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
            sel   <= '0;
          end
        endcase
      end
    end
  end

  assign sel_o         = sel;
  assign busy_o        = (state != IDLE);
  assign frame_o       = frame;
  assign frame_valid_o = frame_valid;

`ifdef SCAN_IRQ_EN
  logic irq;

  // Set on the same edge that raises frame_valid_o; a coincident clear loses.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq <= 1'b0;
    end else if (frame_done) begin
      irq <= 1'b1;
    end else if (irq_clr_i) begin
      irq <= 1'b0;
    end
  end

  assign irq_o = irq;
`else
  logic unused_irq;

  assign unused_irq = irq_clr_i ^ frame_done;
  assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
//
// Scoreboard bench for mux_scan_ctrl with WIDTH=4. Each started frame pushes
// its expected contents and the cycle its frame_valid_o pulse must appear in;
// a monitor on the falling edge pops and compares whenever frame_valid_o is
// high. The sel_o sequence of each scan is compared against a per-channel
// cost model. Define SCAN_IRQ_EN for both bench and RTL to exercise irq_o.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

  localparam int W  = 4;
  localparam int LW = 2;
  localparam int DW = 8;

`ifdef SCAN_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          cont;
  logic [DW-1:0] dwell;
  logic [W-1:0]  mask;
  logic [W-1:0]  data;
  logic [LW-1:0] sel;
  logic          busy;
  logic [W-1:0]  frame;
  logic          fvalid;
  logic          irq_clr;
  logic          irq;

  mux_scan_ctrl #(
    .WIDTH     (W),
    .LOG_WIDTH (LW),
    .DWELL_W   (DW)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .start_i       (start),
    .stop_i        (stop),
    .continuous_i  (cont),
    .dwell_i       (dwell),
    .mask_i        (mask),
    .data_i        (data),
    .sel_o         (sel),
    .busy_o        (busy),
    .frame_o       (frame),
    .frame_valid_o (fvalid),
    .irq_clr_i     (irq_clr),
    .irq_o         (irq)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] frame;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] last_frame = '0;
  int           n_chk = 0;
  int           n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Frame publication monitor.
  always @(negedge clk) begin
    if (!rst && fvalid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_valid", 32'(fvalid), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        check_eq("frame", 32'(frame), 32'(mon_e.frame));
        check_eq("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
        check_eq("irq_on_valid", 32'(irq), 32'(IRQ_EN));
        last_frame = mon_e.frame;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int chan_cost(input logic [DW-1:0] d, input logic m);
    return m ? 1 : int'(d) + 3;
  endfunction

  function automatic int scan_cost(input logic [DW-1:0] d, input logic [W-1:0] m);
    int s = 0;
    for (int c = 0; c < W; c++) s += chan_cost(d, m[c]);
    return s;
  endfunction

  // Raise start; returns the edge index that samples it.
  task automatic start_scan(input logic [DW-1:0] d, input logic [W-1:0] m,
                            input logic [W-1:0] x, output int s);
    dwell = d;
    mask  = m;
    data  = x;
    start = 1'b1;
    s     = cyc + 1;
  endtask

  // One complete single-shot scan with sel_o trace check.
  task automatic run_scan(input string tag, input logic [DW-1:0] d, input logic [W-1:0] m,
                          input logic [W-1:0] x, input logic clr_at_done);
    int   s;
    int   bad;
    exp_t e;
    start_scan(d, m, x, s);
    e.frame = x & ~m;
    e.cyc   = s + scan_cost(d, m) + 1;
    sb.push_back(e);
    bad = 0;
    for (int c = 0; c < W; c++) begin
      for (int k = 0; k < chan_cost(d, m[c]); k++) begin
        tick();
        start = 1'b0;
        if (sel !== LW'(c) || busy !== 1'b1) bad++;
      end
    end
    // DONE cycle
    tick();
    if (sel !== LW'(W - 1) || busy !== 1'b1) bad++;
    if (clr_at_done) irq_clr = 1'b1;
    // Valid cycle: monitor has compared the frame already.
    tick();
    irq_clr = 1'b0;
    check_eq({tag, "_sel_trace"}, 32'(bad), 32'(0));
    check_eq({tag, "_busy_drop"}, 32'(busy), 32'(0));
    check_eq({tag, "_sel_idle"}, 32'(sel), 32'(0));
    check_eq({tag, "_sb_drained"}, 32'(sb.size()), 32'(0));
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 300 && sb.size() != 0; k++) tick();
    check_eq({tag, "_drain"}, 32'(sb.size()), 32'(0));
  endtask

  initial begin
    int           s;
    int           nvalid;
    exp_t         e;
    logic [W-1:0] cdata[3];
    logic [W-1:0] held;

    rst     = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    cont    = 1'b0;
    dwell   = '0;
    mask    = '0;
    data    = '0;
    irq_clr = 1'b0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_sel", 32'(sel), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_frame", 32'(frame), 32'(0));
    check_eq("rst_valid", 32'(fvalid), 32'(0));
    check_eq("rst_irq", 32'(irq), 32'(0));
    rst = 1'b0;
    tick();

    // Plain scan: 4 x 3 cycles, valid 13 edges after start
    run_scan("basic", 8'd0, 4'b0000, 4'b1010, 1'b0);
    repeat (3) tick();
    check_eq("irq_sticky", 32'(irq), 32'(IRQ_EN));
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check_eq("irq_clear", 32'(irq), 32'(0));

    // Masked scan with dwell, clear coincident with frame completion
    run_scan("mask_dwell", 8'd2, 4'b0101, 4'b1111, 1'b1);
    check_eq("irq_set_wins", 32'(irq), 32'(IRQ_EN));
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;

    // Fully masked: WIDTH cycles of channels, frame zero
    run_scan("all_mask", 8'd5, 4'b1111, 4'b1111, 1'b0);

    // Continuous mode: three frames, data changed after each pulse
    cdata[0] = 4'b0110;
    cdata[1] = 4'b1001;
    cdata[2] = 4'b1111;
    cont = 1'b1;
    start_scan(8'd1, 4'b0010, cdata[0], s);
    e.frame = cdata[0] & ~4'b0010;
    e.cyc   = s + scan_cost(8'd1, 4'b0010) + 1;
    sb.push_back(e);
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_drain("cont");
      if (k < 2) begin
        data = cdata[k+1];
        if (k == 1) cont = 1'b0;
        e.frame = cdata[k+1] & ~4'b0010;
        e.cyc   = e.cyc + scan_cost(8'd1, 4'b0010) + 1;
        sb.push_back(e);
      end
    end
    tick();
    check_eq("cont_end_idle", 32'(busy), 32'(0));

    // Stop during SETTLE of channel 2
    held = last_frame;
    start_scan(8'd3, 4'b0000, 4'b1111, s);
    for (int k = 0; k < 14; k++) begin
      tick();
      start = 1'b0;
    end
    check_eq("stop_pre_sel", 32'(sel), 32'(2));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("stop_busy", 32'(busy), 32'(0));
    check_eq("stop_sel", 32'(sel), 32'(0));
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      if (fvalid) nvalid++;
      tick();
    end
    check_eq("stop_no_valid", 32'(nvalid), 32'(0));
    check_eq("stop_frame_held", 32'(frame), 32'(held));

    // Start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    check_eq("startstop_busy0", 32'(busy), 32'(0));
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_eq("startstop_busy1", 32'(busy), 32'(0));

    // Reset in the middle of a scan
    run_scan("pre_rst", 8'd0, 4'b0000, 4'b0011, 1'b0);
    start_scan(8'd1, 4'b0000, 4'b1100, s);
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check_eq("mrst_sel", 32'(sel), 32'(0));
    check_eq("mrst_busy", 32'(busy), 32'(0));
    check_eq("mrst_frame", 32'(frame), 32'(0));
    check_eq("mrst_valid", 32'(fvalid), 32'(0));
    check_eq("mrst_irq", 32'(irq), 32'(0));
    rst = 1'b0;
    last_frame = '0;
    repeat (3) tick();
    check_eq("final_sb_empty", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
